// File: rtl/vga_timing_pkg.sv
// ============================================================================
// Module : vga_timing_pkg
// Brief  : VGA raster timing constants shared by generator and receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_timing_pkg;

  localparam int H_TOTAL      = 800;
  localparam int H_DISP_START = 144;
  localparam int H_ACTIVE     = 640;
  localparam int V_TOTAL      = 521;
  localparam int V_DISP_START = 31;
  localparam int V_ACTIVE     = 480;

  localparam int COLOR_W = 12;
  localparam int CNT_W   = 10;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } sync_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_edge_sync.sv
// ============================================================================
// Module : vga_edge_sync
// Brief  : Enable-qualified two-stage sync sampler with falling-edge detect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_sig,
  output logic o_fall
);

  logic r_q;
  logic r_qq;

  // Both stages reset to the idle (high) level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q  <= 1'b1;
      r_qq <= 1'b1;
    end else if (i_en) begin
      r_q  <= i_sig;
      r_qq <= r_q;
    end
  end

  assign o_fall = r_qq & ~r_q;

endmodule

`default_nettype wire

// File: rtl/vga_sync_receiver.sv
// ============================================================================
// Module : vga_sync_receiver
// Brief  : Locks to incoming HS/VS, checks raster lengths, emits pixel stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL_CFG      = H_TOTAL,
  parameter int H_DISP_START_CFG = H_DISP_START,
  parameter int H_ACTIVE_CFG     = H_ACTIVE,
  parameter int V_TOTAL_CFG      = V_TOTAL,
  parameter int V_DISP_START_CFG = V_DISP_START,
  parameter int V_ACTIVE_CFG     = V_ACTIVE
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PIX_EN,
  input  logic               HS_IN,
  input  logic               VS_IN,
  input  logic [COLOR_W-1:0] COLOR_IN,
  output logic               PIX_VALID,
  output logic [9:0]         ADDRH,
  output logic [8:0]         ADDRV,
  output logic [COLOR_W-1:0] COLOR_OUT,
  output logic               FRAME_START,
  output logic               LOCKED,
  output logic               SYNC_ERR
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic               w_hs_fall;
  logic               w_vs_fall;
  logic [COLOR_W-1:0] r_col_q;
  logic [COLOR_W-1:0] r_col_qq;
  logic [CNT_W-1:0]   r_h_cnt;
  logic [CNT_W-1:0]   r_v_cnt;
  logic [CNT_W-1:0]   w_h_next;
  logic [CNT_W-1:0]   w_v_next;
  logic               w_line_ok;
  logic               w_frame_ok;
  logic               w_viol;
  logic               w_in_win;
  logic               w_err;
  logic               w_fs;
  sync_state_e        r_state;
  sync_state_e        w_state_next;

  vga_edge_sync u_hs_sync (
    .clk   (CLK),
    .rst   (RESET),
    .i_en  (PIX_EN),
    .i_sig (HS_IN),
    .o_fall(w_hs_fall)
  );

  vga_edge_sync u_vs_sync (
    .clk   (CLK),
    .rst   (RESET),
    .i_en  (PIX_EN),
    .i_sig (VS_IN),
    .o_fall(w_vs_fall)
  );

  // Colour rides two stages so it lines up with the counter of the same sample.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_col_q  <= '0;
      r_col_qq <= '0;
    end else if (PIX_EN) begin
      r_col_q  <= COLOR_IN;
      r_col_qq <= r_col_q;
    end
  end

  always_comb begin
    w_h_next = (r_h_cnt == C_CNT_MAX) ? C_CNT_MAX : r_h_cnt + 1'b1;
    if (w_hs_fall) w_h_next = '0;
    w_v_next = r_v_cnt;
    if (w_hs_fall && (r_v_cnt != C_CNT_MAX)) w_v_next = r_v_cnt + 1'b1;
    if (w_vs_fall) w_v_next = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (PIX_EN) begin
      r_h_cnt <= w_h_next;
      r_v_cnt <= w_v_next;
    end
  end

  assign w_line_ok  = w_hs_fall & (r_h_cnt == CNT_W'(H_TOTAL_CFG - 1));
  assign w_frame_ok = w_vs_fall & (r_v_cnt == CNT_W'(V_TOTAL_CFG - 1));
  // A counter arriving at (or sitting on) saturation means the sync went missing.
  assign w_viol = (w_hs_fall & ~w_line_ok) | (w_vs_fall & ~w_frame_ok) |
                  (w_h_next == C_CNT_MAX) | (w_v_next == C_CNT_MAX);

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_SEARCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (PIX_EN) begin
      case (r_state)
        ST_SEARCH:  if (w_vs_fall) w_state_next = ST_MEASURE;
        ST_MEASURE: begin
          if (w_viol)          w_state_next = ST_SEARCH;
          else if (w_frame_ok) w_state_next = ST_LOCKED;
        end
        ST_LOCKED:  if (w_viol) w_state_next = ST_SEARCH;
        default:    w_state_next = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    w_err = 1'b0;
    w_fs  = 1'b0;
    if (PIX_EN) begin
      case (r_state)
        ST_MEASURE: w_err = w_viol;
        ST_LOCKED: begin
          w_err = w_viol;
          w_fs  = ~w_viol & w_frame_ok;
        end
        default: ;
      endcase
    end
  end

  assign w_in_win = (r_h_cnt >= CNT_W'(H_DISP_START_CFG)) &&
                    (r_h_cnt <  CNT_W'(H_DISP_START_CFG + H_ACTIVE_CFG)) &&
                    (r_v_cnt >= CNT_W'(V_DISP_START_CFG)) &&
                    (r_v_cnt <  CNT_W'(V_DISP_START_CFG + V_ACTIVE_CFG));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PIX_VALID   <= 1'b0;
      ADDRH       <= '0;
      ADDRV       <= '0;
      COLOR_OUT   <= '0;
      FRAME_START <= 1'b0;
      LOCKED      <= 1'b0;
      SYNC_ERR    <= 1'b0;
    end else begin
      PIX_VALID   <= PIX_EN & (r_state == ST_LOCKED) & w_in_win;
      FRAME_START <= w_fs;
      SYNC_ERR    <= w_err;
      LOCKED      <= (w_state_next == ST_LOCKED);
      if (PIX_EN && w_in_win) begin
        ADDRH     <= r_h_cnt - CNT_W'(H_DISP_START_CFG);
        ADDRV     <= r_v_cnt[8:0] - 9'(V_DISP_START_CFG);
        COLOR_OUT <= r_col_qq;
      end
    end
  end

endmodule

`default_nettype wire
